// File: rtl/bnn_param_loader.sv
// Serial parameter-chain loader: streams bytes MSB first onto setup_out/param_out.
// Optional serial CRC-8 (poly 0x07) of the driven bits when PARAM_CRC_EN is defined.
module bnn_param_loader #(
  parameter int unsigned CHAIN_BITS = 144
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [7:0]                        s_data,
  input  logic                              s_valid,
  output logic                              s_ready,
  output logic                              setup_out,
  output logic                              param_out,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(CHAIN_BITS+1)-1:0]   bit_count,
  output logic [7:0]                        crc
);

  localparam int unsigned CW = $clog2(CHAIN_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  sreg;
  logic [3:0]  rem;
  logic [CW-1:0] bc;
  logic        shift_c, ready_c, accept_c;
  logic [31:0] left_c;
  logic [3:0]  rem_load_c;

  // Handshake and shift qualifiers; a new byte is loaded with only the bits still owed to the chain.
  always_comb begin
    shift_c    = (state == S_LOAD) && (rem != 4'd0);
    ready_c    = (state == S_LOAD) && (rem <= 4'd1) &&
                 ((32'(bc) + 32'(rem)) < CHAIN_BITS);
    accept_c   = ready_c && s_valid;
    left_c     = CHAIN_BITS - 32'(bc) - (shift_c ? 32'd1 : 32'd0);
    rem_load_c = (left_c >= 32'd8) ? 4'd8 : 4'(left_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: if (shift_c && ((32'(bc) + 32'd1) == CHAIN_BITS)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift register, unsent-bit count and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= 8'h00;
      rem  <= 4'd0;
      bc   <= '0;
    end else if ((state == S_IDLE) && start) begin
      sreg <= 8'h00;
      rem  <= 4'd0;
      bc   <= '0;
    end else begin
      if (shift_c) bc <= bc + CW'(1);
      if (accept_c) begin
        sreg <= s_data;
        rem  <= rem_load_c;
      end else if (shift_c) begin
        sreg <= {sreg[6:0], 1'b0};
        rem  <= rem - 4'd1;
      end
    end
  end

`ifdef PARAM_CRC_EN
  logic [7:0] crc_q, crc_nx_c;
  logic       fb_c;

  // Serial CRC-8 over each bit as it is driven
  always_comb begin
    fb_c     = crc_q[7] ^ sreg[7];
    crc_nx_c = {crc_q[6:0], 1'b0} ^ (fb_c ? 8'h07 : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset)                        crc_q <= 8'h00;
    else if ((state == S_IDLE) && start) crc_q <= 8'h00;
    else if (shift_c)                 crc_q <= crc_nx_c;
  end
`endif

  // Outputs are decoded from flops only, so they are zero right after a reset edge.
  always_comb begin
    s_ready   = ready_c;
    setup_out = shift_c;
    param_out = shift_c & sreg[7];
    busy      = (state == S_LOAD);
    done      = (state == S_DONE);
    bit_count = bc;
`ifdef PARAM_CRC_EN
    crc       = crc_q;
`else
    crc       = 8'h00;
`endif
  end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: three instances (16, 12 and 8 chain bits), table-driven loads
// with a bit scoreboard, plus reset-abort and ignored-input sequences.
module tb_bnn_param_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start   [3];
  logic       s_valid [3];
  logic [7:0] s_data  [3];
  logic       s_ready [3];
  logic       setup_out [3];
  logic       param_out [3];
  logic       busy    [3];
  logic       done    [3];
  logic [7:0] crc     [3];
  logic [4:0] bc0;
  logic [3:0] bc1, bc2;

  bnn_param_loader #(.CHAIN_BITS(16)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .setup_out(setup_out[0]), .param_out(param_out[0]),
    .busy(busy[0]), .done(done[0]), .bit_count(bc0), .crc(crc[0]));
  bnn_param_loader #(.CHAIN_BITS(12)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .setup_out(setup_out[1]), .param_out(param_out[1]),
    .busy(busy[1]), .done(done[1]), .bit_count(bc1), .crc(crc[1]));
  bnn_param_loader #(.CHAIN_BITS(8)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .s_data(s_data[2]), .s_valid(s_valid[2]),
    .s_ready(s_ready[2]), .setup_out(setup_out[2]), .param_out(param_out[2]),
    .busy(busy[2]), .done(done[2]), .bit_count(bc2), .crc(crc[2]));

  typedef struct {
    int         d;
    int         nb;
    logic [7:0] b0;
    logic [7:0] b1;
    int         gap1;
    bit         hold;
    int         exp_n;
    logic [15:0] exp_bits;
    int         exp_stall;
    logic [7:0] exp_crc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit          exp_q[$];
  bit          e;
  int          act = 0;
  int          cnt, stall, pushed;
  logic [15:0] cap;
  int          done_cnt [3];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic int cb(input int d);
    case (d)
      0: return 16;
      1: return 12;
      default: return 8;
    endcase
  endfunction

  function automatic int get_bc(input int d);
    case (d)
      0: return int'(bc0);
      1: return int'(bc1);
      default: return int'(bc2);
    endcase
  endfunction

  function automatic logic [7:0] crc_exp(input logic [15:0] bits, input int n);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[7] ^ bits[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`ifdef PARAM_CRC_EN
    return c;
`else
    return 8'h00;
`endif
  endfunction

  // Bit monitor: every setup_out pulse on the active instance must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (!setup_out[i]) chk("param_out_when_no_setup", int'(param_out[i]), 0);
        chk("setup_outside_load", int'(setup_out[i] & ~busy[i]), 0);
        if (i != act) chk("setup_on_idle_instance", int'(setup_out[i]), 0);
        if (done[i]) done_cnt[i]++;
      end
      if (setup_out[act]) begin
        chk("bit_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("param_bit", int'(param_out[act]), int'(e));
        end
        cap = {cap[14:0], param_out[act]};
        cnt++;
      end else if (busy[act] && cnt > 0) begin
        stall++;
      end
    end
  end

  task automatic push_bits(input int d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (pushed < cb(d)) begin
        exp_q.push_back(b[i]);
        pushed++;
      end
    end
  endtask

  // Offer one byte; gap = cycles with s_ready high that s_valid is withheld first.
  task automatic feed_byte(input int d, input logic [7:0] b, input int gap);
    int g;
    bit acc;
    g   = gap;
    acc = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      s_data[d]  = b;
      s_valid[d] = (g == 0);
      @(negedge clk);
      acc = s_ready[d] && s_valid[d];
      if (s_ready[d] && !s_valid[d] && g > 0) g--;
      if (acc) push_bits(d, b);
      @(posedge clk); #1;
    end
    s_valid[d] = 1'b0;
    chk("byte_accepted", int'(acc), 1);
  endtask

  task automatic check_zero(input int d);
    chk("rst_s_ready",   int'(s_ready[d]),   0);
    chk("rst_setup_out", int'(setup_out[d]), 0);
    chk("rst_param_out", int'(param_out[d]), 0);
    chk("rst_busy",      int'(busy[d]),      0);
    chk("rst_done",      int'(done[d]),      0);
    chk("rst_bit_count", get_bc(d),          0);
    chk("rst_crc",       int'(crc[d]),       0);
  endtask

  task automatic run_vec(input vec_t v);
    int  dc0;
    bit  got_done, any_ready;
    act    = v.d;
    cnt    = 0;
    stall  = 0;
    cap    = 16'h0;
    pushed = 0;
    exp_q.delete();
    dc0 = done_cnt[v.d];
    start[v.d] = 1'b1;
    @(posedge clk); #1;
    start[v.d] = v.hold;
    feed_byte(v.d, v.b0, 0);
    if (v.nb > 1) feed_byte(v.d, v.b1, v.gap1);
    got_done  = 1'b0;
    any_ready = 1'b0;
    for (int k = 0; k < 200 && !got_done; k++) begin
      @(negedge clk);
      if (done[v.d]) got_done = 1'b1;
      else if (s_ready[v.d]) any_ready = 1'b1;
    end
    chk("done_seen", int'(got_done), 1);
    #1;
    chk("bit_count_at_done", get_bc(v.d), cb(v.d));
    chk("crc_at_done", int'(crc[v.d]), int'(v.exp_crc));
    chk("bit_sequence", int'(cap), int'(v.exp_bits));
    chk("setup_pulses", cnt, v.exp_n);
    chk("stall_cycles", stall, v.exp_stall);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ready_after_last_byte", int'(any_ready), 0);
    @(posedge clk); #1;
    start[v.d] = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", int'(done[v.d]), 0);
    chk("busy_after_done", int'(busy[v.d]), 0);
    chk("bit_count_hold", get_bc(v.d), cb(v.d));
    chk("crc_hold", int'(crc[v.d]), int'(v.exp_crc));
    chk("done_pulse_count", done_cnt[v.d] - dc0, 1);
    @(posedge clk); #1;
  endtask

  vec_t vt [6];

  initial begin
    vt[0] = '{0, 2, 8'hA5, 8'h3C, 0, 1'b0, 16, 16'hA53C, 0, 8'h00};
    vt[1] = '{0, 2, 8'hA5, 8'h3C, 5, 1'b0, 16, 16'hA53C, 5, 8'h00};
    vt[2] = '{1, 2, 8'hFF, 8'h0F, 0, 1'b0, 12, 16'h0FF0, 0, 8'h00};
    vt[3] = '{2, 1, 8'h01, 8'h00, 0, 1'b0,  8, 16'h0001, 0, 8'h00};
    vt[4] = '{0, 2, 8'h3C, 8'hA5, 0, 1'b1, 16, 16'h3CA5, 0, 8'h00};
    vt[5] = '{1, 2, 8'h5A, 8'hC3, 2, 1'b0, 12, 16'h05AC, 2, 8'h00};
    for (int i = 0; i < 6; i++) vt[i].exp_crc = crc_exp(vt[i].exp_bits, vt[i].exp_n);
`ifdef PARAM_CRC_EN
    vt[3].exp_crc = 8'h07;
`else
    vt[3].exp_crc = 8'h00;
`endif

    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; s_valid[i] = 1'b0; s_data[i] = 8'h00; done_cnt[i] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // s_valid while idle: nothing accepted, block stays idle
    act = 0;
    s_data[0]  = 8'hFF;
    s_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_s_ready", int'(s_ready[0]), 0);
      chk("idle_busy", int'(busy[0]), 0);
      chk("idle_bit_count_hold", get_bc(0), 16);
      @(posedge clk); #1;
    end
    s_valid[0] = 1'b0;

    // Reset after five bits of a load aborts it without a done pulse
    begin
      int dc0;
      act = 0; cnt = 0; stall = 0; cap = 16'h0; pushed = 0;
      exp_q.delete();
      dc0 = done_cnt[0];
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      feed_byte(0, 8'hA5, 0);
      for (int k = 0; k < 20 && cnt < 5; k++) begin
        @(negedge clk); #1;
      end
      chk("bits_before_reset", cnt, 5);
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check_zero(0);
      #1 reset = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      @(negedge clk);
      chk("no_done_after_abort", done_cnt[0] - dc0, 0);
      chk("idle_after_abort", int'(busy[0]), 0);
      @(posedge clk); #1;
    end
    run_vec(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
